// File: rtl/pw_trigger_sequencer.sv
// pw_trigger_sequencer
// Arms the pattern matcher, waits for a match and waits a programmable delay.
// It then emits a train of programmable-width trigger pulses.
// Timing is in the fe_clk domain.
// O_state shows the live FSM state.
// The other outputs are registered from that state, so they follow it by one cycle.
// Abort and arm-release are also folded into the output registers.
// This lets them drop on the same edge that the FSM returns to IDLE.
module pw_trigger_sequencer #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 8
) (
    input  logic                    fe_clk,
    input  logic                    reset_n,
    input  logic                    I_arm,
    input  logic                    I_match,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_width,
    input  logic [pWIDTH_WIDTH-1:0] I_gap,
    input  logic [pCOUNT_WIDTH-1:0] I_num_pulses,
    output logic                    O_pm_arm,
    output logic                    O_trigger,
    output logic                    O_busy,
    output logic                    O_done,
    output logic [2:0]              O_state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_MATCH = 3'd1,
        ST_DELAY      = 3'd2,
        ST_PULSE      = 3'd3,
        ST_GAP        = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Zero-length pulse/gap settings behave as one cycle.
    function automatic logic [pWIDTH_WIDTH-1:0] clamp_width(input logic [pWIDTH_WIDTH-1:0] v);
        clamp_width = (v == pWIDTH_WIDTH'(0)) ? pWIDTH_WIDTH'(1) : v;
    endfunction

    // A zero pulse count behaves as a single pulse.
    function automatic logic [pCOUNT_WIDTH-1:0] clamp_count(input logic [pCOUNT_WIDTH-1:0] v);
        clamp_count = (v == pCOUNT_WIDTH'(0)) ? pCOUNT_WIDTH'(1) : v;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    arm_d_r;
    logic                    arm_rise_s;
    logic                    busy_state_s;
    logic                    abort_s;
    logic                    capture_s;

    logic [pDELAY_WIDTH-1:0] delay_sh_r;
    logic [pWIDTH_WIDTH-1:0] width_sh_r;
    logic [pWIDTH_WIDTH-1:0] gap_sh_r;

    logic [pDELAY_WIDTH-1:0] delay_cnt_r;
    logic [pDELAY_WIDTH-1:0] delay_cnt_nxt_s;
    logic [pWIDTH_WIDTH-1:0] width_cnt_r;
    logic [pWIDTH_WIDTH-1:0] width_cnt_nxt_s;
    logic [pCOUNT_WIDTH-1:0] pulses_left_r;
    logic [pCOUNT_WIDTH-1:0] pulses_left_nxt_s;

    logic                    pm_arm_r;
    logic                    trigger_r;
    logic                    busy_r;
    logic                    done_r;

    assign arm_rise_s   = I_arm & ~arm_d_r;
    assign busy_state_s = (state_r == ST_WAIT_MATCH) || (state_r == ST_DELAY) ||
                          (state_r == ST_PULSE)      || (state_r == ST_GAP);
    assign abort_s      = busy_state_s & ~I_arm;

    // Next-state and counter logic; abort is checked before every other transition.
    always_comb begin
        state_nxt_s       = state_r;
        delay_cnt_nxt_s   = delay_cnt_r;
        width_cnt_nxt_s   = width_cnt_r;
        pulses_left_nxt_s = pulses_left_r;
        capture_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm_rise_s) begin
                    state_nxt_s       = ST_WAIT_MATCH;
                    capture_s         = 1'b1;
                    pulses_left_nxt_s = clamp_count(I_num_pulses);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_MATCH: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (I_match) begin
                    if (delay_sh_r == pDELAY_WIDTH'(0)) begin
                        state_nxt_s     = ST_PULSE;
                        width_cnt_nxt_s = width_sh_r - pWIDTH_WIDTH'(1);
                    end else begin
                        state_nxt_s     = ST_DELAY;
                        delay_cnt_nxt_s = delay_sh_r - pDELAY_WIDTH'(1);
                    end
                end else begin
                    state_nxt_s = ST_WAIT_MATCH;
                end
            end
            ST_DELAY: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (delay_cnt_r == pDELAY_WIDTH'(0)) begin
                    state_nxt_s     = ST_PULSE;
                    width_cnt_nxt_s = width_sh_r - pWIDTH_WIDTH'(1);
                end else begin
                    delay_cnt_nxt_s = delay_cnt_r - pDELAY_WIDTH'(1);
                end
            end
            ST_PULSE: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (width_cnt_r == pWIDTH_WIDTH'(0)) begin
                    if (pulses_left_r > pCOUNT_WIDTH'(1)) begin
                        state_nxt_s       = ST_GAP;
                        width_cnt_nxt_s   = gap_sh_r - pWIDTH_WIDTH'(1);
                        pulses_left_nxt_s = pulses_left_r - pCOUNT_WIDTH'(1);
                    end else begin
                        state_nxt_s       = ST_DONE;
                        pulses_left_nxt_s = pCOUNT_WIDTH'(0);
                    end
                end else begin
                    width_cnt_nxt_s = width_cnt_r - pWIDTH_WIDTH'(1);
                end
            end
            ST_GAP: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (width_cnt_r == pWIDTH_WIDTH'(0)) begin
                    state_nxt_s     = ST_PULSE;
                    width_cnt_nxt_s = width_sh_r - pWIDTH_WIDTH'(1);
                end else begin
                    width_cnt_nxt_s = width_cnt_r - pWIDTH_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (!I_arm) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and arm edge detector.
    // arm_d_r resets high, so an arm held high across reset must be re-pulsed.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            arm_d_r       <= 1'b1;
            delay_cnt_r   <= '0;
            width_cnt_r   <= '0;
            pulses_left_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            arm_d_r       <= I_arm;
            delay_cnt_r   <= delay_cnt_nxt_s;
            width_cnt_r   <= width_cnt_nxt_s;
            pulses_left_r <= pulses_left_nxt_s;
        end
    end

    // Shadow copies of the configuration; these are frozen for the whole sequence.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_sh_r <= '0;
            width_sh_r <= pWIDTH_WIDTH'(1);
            gap_sh_r   <= pWIDTH_WIDTH'(1);
        end else if (capture_s) begin
            delay_sh_r <= I_delay;
            width_sh_r <= clamp_width(I_width);
            gap_sh_r   <= clamp_width(I_gap);
        end
    end

    // Registered outputs.
    // Abort and arm-release clear them on the same edge that the FSM leaves.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            pm_arm_r  <= 1'b0;
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            pm_arm_r  <= busy_state_s & ~abort_s;
            trigger_r <= (state_r == ST_PULSE) & ~abort_s;
            busy_r    <= busy_state_s & ~abort_s;
            done_r    <= (state_r == ST_DONE) & I_arm;
        end
    end

    assign O_pm_arm  = pm_arm_r;
    assign O_trigger = trigger_r;
    assign O_busy    = busy_r;
    assign O_done    = done_r;
    assign O_state   = state_r;

endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// Self-checking bench for pw_trigger_sequencer.
// Expected per-cycle outputs are derived from the timing rules and queued when a match is driven.
// They are popped and compared one per clock.
module tb_pw_trigger_sequencer;

    logic        fe_clk;
    logic        reset_n;
    logic        I_arm;
    logic        I_match;
    logic [19:0] I_delay;
    logic [16:0] I_width;
    logic [16:0] I_gap;
    logic [7:0]  I_num_pulses;
    logic        O_pm_arm;
    logic        O_trigger;
    logic        O_busy;
    logic        O_done;
    logic [2:0]  O_state;

    typedef struct {
        logic trig;
        logic busy;
        logic done;
        logic pm;
        int   r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    pw_trigger_sequencer #(
        .pDELAY_WIDTH(20),
        .pWIDTH_WIDTH(17),
        .pCOUNT_WIDTH(8)
    ) dut (
        .fe_clk      (fe_clk),
        .reset_n     (reset_n),
        .I_arm       (I_arm),
        .I_match     (I_match),
        .I_delay     (I_delay),
        .I_width     (I_width),
        .I_gap       (I_gap),
        .I_num_pulses(I_num_pulses),
        .O_pm_arm    (O_pm_arm),
        .O_trigger   (O_trigger),
        .O_busy      (O_busy),
        .O_done      (O_done),
        .O_state     (O_state)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        exp_t e;
        @(posedge fe_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("trig r%0d", e.r), 32'(O_trigger), 32'(e.trig));
            check_eq($sformatf("busy r%0d", e.r), 32'(O_busy),    32'(e.busy));
            check_eq($sformatf("done r%0d", e.r), 32'(O_done),    32'(e.done));
            check_eq($sformatf("pm r%0d",   e.r), 32'(O_pm_arm),  32'(e.pm));
        end
    endtask

    // Expected outputs from the match-sample edge k (r=0) on.
    // Pulse i is high for r in [1+D+i*(W+G), +W).
    // done is set from r = 1+D+P*W+(P-1)*G.
    task automatic push_expect(input int d, input int wp, input int gp, input int pp);
        exp_t e;
        int   done_at;
        int   s;
        done_at = 1 + d + pp * wp + (pp - 1) * gp;
        for (int r = 0; r <= done_at + 1; r++) begin
            e.trig = 1'b0;
            for (int i = 0; i < pp; i++) begin
                s = 1 + d + i * (wp + gp);
                if (r >= s && r < s + wp) e.trig = 1'b1;
            end
            e.done = (r >= done_at);
            e.busy = !e.done;
            e.pm   = !e.done;
            e.r    = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " trig"},  32'(O_trigger), 32'd0);
        check_eq({tag, " pm"},    32'(O_pm_arm),  32'd0);
        check_eq({tag, " busy"},  32'(O_busy),    32'd0);
        check_eq({tag, " done"},  32'(O_done),    32'd0);
        check_eq({tag, " state"}, 32'(O_state),   32'd0);
    endtask

    // Arms, matches after pre_wait cycles and checks the full train.
    // The run is either aborted at abort_at or ends by releasing the arm.
    task automatic run_seq(input int d, input int w, input int g, input int p,
                           input int pre_wait, input int abort_at, input bit disturb);
        int wp;
        int gp;
        int pp;
        int j;
        wp = (w == 0) ? 1 : w;
        gp = (g == 0) ? 1 : g;
        pp = (p == 0) ? 1 : p;
        I_delay      = 20'(d);
        I_width      = 17'(w);
        I_gap        = 17'(g);
        I_num_pulses = 8'(p);
        I_arm        = 1'b1;
        I_match      = 1'b1;              // coincident with arm rise: must be ignored
        step();
        I_match = 1'b0;
        check_eq("armed state", 32'(O_state), 32'd1);
        check_eq("pm before",   32'(O_pm_arm), 32'd0);
        step();
        check_eq("pm after arm", 32'(O_pm_arm), 32'd1);
        check_eq("busy waiting", 32'(O_busy),   32'd1);
        check_eq("wait state",   32'(O_state),  32'd1);
        repeat (pre_wait) step();
        push_expect(d, wp, gp, pp);
        I_match = 1'b1;
        j = 0;
        while (exp_q.size() > 0 && j < 2000) begin
            step();
            j++;
            if (j == 1) I_match = 1'b0;
            if (disturb) begin
                if (j == 2) begin
                    I_delay = 20'd50;
                    I_match = 1'b1;
                end
                if (j == 3) I_match = 1'b0;
                if (j == d + wp + 1) I_match = 1'b1;
                if (j == d + wp + 2) I_match = 1'b0;
            end
            if (abort_at > 0 && j == abort_at) begin
                I_arm = 1'b0;
                exp_q.delete();
            end
        end
        if (exp_q.size() > 0) begin
            check_eq("timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        if (abort_at > 0) begin
            step();
            check_idle("abort");
        end else begin
            check_eq("done state", 32'(O_state), 32'd5);
            I_arm = 1'b0;
            step();
            check_idle("disarm");
        end
        step();
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset_n      = 1'b0;
        I_arm        = 1'b0;
        I_match      = 1'b0;
        I_delay      = 20'd0;
        I_width      = 17'd0;
        I_gap        = 17'd0;
        I_num_pulses = 8'd0;
        #1;
        check_idle("in reset");
        repeat (3) @(posedge fe_clk);
        #1;
        reset_n = 1'b1;
        step();
        check_idle("post reset");

        run_seq(0, 1, 1, 1, 8, 0, 1'b0);     // single 1-cycle pulse, no delay
        run_seq(5, 3, 2, 3, 2, 0, 1'b1);     // delay/gap, config change and stray matches
        run_seq(0, 0, 0, 0, 0, 0, 1'b0);     // zero settings clamp to 1/1/1
        run_seq(1, 1, 1, 4, 3, 0, 1'b0);     // tight 4-pulse train
        run_seq(0, 100, 1, 1, 1, 10, 1'b0);  // abort mid-pulse

        // Asynchronous reset in the middle of a gap.
        I_delay      = 20'd0;
        I_width      = 17'd2;
        I_gap        = 17'd20;
        I_num_pulses = 8'd2;
        I_arm        = 1'b1;
        step();
        step();
        I_match = 1'b1;
        step();
        I_match = 1'b0;
        repeat (5) step();
        check_eq("in gap state", 32'(O_state), 32'd4);
        check_eq("in gap busy",  32'(O_busy),  32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async reset");
        #1;
        reset_n = 1'b1;
        repeat (4) step();
        check_idle("held arm");
        I_arm = 1'b0;
        step();
        run_seq(2, 2, 1, 2, 1, 0, 1'b0);     // restart after reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
